// File: rtl/mda_hdmi_pkg.sv
// Shared types and constants for the MDA-to-HDMI pixel pipeline.
// The colour table maps the two-bit mode switch onto the three colour guns.
package mda_hdmi_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        WHITE  = 2'd2,
        RED    = 2'd3
    } mda_mode_e;

    // One pixel-path word: everything that travels through the pixel delay line.
    typedef struct packed {
        logic video;
        logic intensity;
        logic hsync;
        logic vsync;
    } mda_pix_t;

    // Colour gun enables per mode, packed as {r, g, b}.
    localparam logic [2:0] RGB_TABLE [4] = '{3'b010, 3'b110, 3'b111, 3'b100};

    localparam int DEF_DE_DELAY     = 2;
    localparam int DEF_PIX_DELAY    = 0;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_SYNC_TIMEOUT = 1048576;

    function automatic logic [2:0] mode_rgb(input mda_mode_e m);
        return RGB_TABLE[m];
    endfunction

endpackage

// File: rtl/mda_hdmi_if.sv
// MDA video input and HDMI-side output bundle for the pixel pipeline.
// The master drives the MDA signals; the slave (the pipeline) drives the HDMI signals.
interface mda_hdmi_if;

    logic       video;
    logic       intensity;
    logic       hsync;
    logic       vsync;
    logic       display_enable;
    logic [1:0] mode;

    logic       hdmi_red;
    logic       hdmi_grn;
    logic       hdmi_blu;
    logic       hdmi_int;
    logic       hdmi_grn_int;
    logic       hdmi_hs;
    logic       hdmi_vs;
    logic       hdmi_de;
    logic       hdmi_clk;
    logic       sync_lost;

    modport master (
        output video, intensity, hsync, vsync, display_enable, mode,
        input  hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int,
        input  hdmi_hs, hdmi_vs, hdmi_de, hdmi_clk, sync_lost
    );

    modport slave (
        input  video, intensity, hsync, vsync, display_enable, mode,
        output hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int,
        output hdmi_hs, hdmi_vs, hdmi_de, hdmi_clk, sync_lost
    );

endinterface

// File: rtl/mda_delay_line.sv
// Fixed-length shift register with synchronous active-low clear.
// DEPTH = 0 degenerates to a plain wire.
module mda_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_s;
        assign unused_s = clk ^ rst_n;
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_r [DEPTH];

        // Shift one stage per clock; reset clears every stage so no old data survives.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_r[i] <= '0;
                end
            end else begin
                stage_r[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign q = stage_r[DEPTH-1];
    end

endmodule

// File: rtl/mda_hdmi_pipe.sv
// MDA-to-HDMI pixel pipeline: delays DE and pixel/sync signals, maps
// monochrome video onto a selectable colour, divides the pixel clock and,
// when MDA_SYNC_WATCHDOG_EN is defined, blanks the picture after vsync loss.
module mda_hdmi_pipe
    import mda_hdmi_pkg::*;
#(
    parameter int DE_DELAY     = DEF_DE_DELAY,
    parameter int PIX_DELAY    = DEF_PIX_DELAY,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
    input  logic      clk,
    input  logic      rst_n,
    mda_hdmi_if.slave bus
);

    localparam int HALF_DIV = CLK_DIV / 2;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    mda_pix_t          pix_in_s;
    mda_pix_t          pix_dly_s;
    logic              de_dly_s;
    logic              vs_rise_s;
    logic              sync_lost_nxt_s;
    logic [2:0]        rgb_s;

    mda_mode_e         mode_r;
    logic              red_r, grn_r, blu_r, int_r, grn_int_r;
    logic              hs_r, vs_r, de_r;
    logic              sync_lost_r;
    logic              hclk_r;
    logic [DIV_W-1:0]  div_cnt_r;

    assign pix_in_s = '{video: bus.video, intensity: bus.intensity,
                        hsync: bus.hsync, vsync: bus.vsync};

    mda_delay_line #(.WIDTH($bits(mda_pix_t)), .DEPTH(PIX_DELAY)) u_pix_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pix_in_s),
        .q     (pix_dly_s)
    );

    mda_delay_line #(.WIDTH(1), .DEPTH(DE_DELAY)) u_de_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.display_enable),
        .q     (de_dly_s)
    );

    // vs_r holds the previous cycle's delayed vsync, so this is the 0->1 edge.
    assign vs_rise_s = pix_dly_s.vsync & ~vs_r;
    assign rgb_s     = mode_rgb(mode_r);

`ifdef MDA_SYNC_WATCHDOG_EN
    localparam int WD_W = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(SYNC_TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_cnt_r;

    // Sync counts as lost once the counter has saturated, unless an edge arrives now.
    assign sync_lost_nxt_s = vs_rise_s ? 1'b0 : (wd_cnt_r == WD_MAX);

    // Cycles since the last vsync edge, saturating at the timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (vs_rise_s) begin
            wd_cnt_r <= '0;
        end else if (wd_cnt_r != WD_MAX) begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    // The timeout only sizes the watchdog, which this build leaves out.
    logic unused_cfg_s;
    assign unused_cfg_s    = (SYNC_TIMEOUT > 0);
    assign sync_lost_nxt_s = 1'b0;
`endif

    // Active colour mode: only changes on a vsync edge so a frame never changes colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r <= GREEN;
        end else if (vs_rise_s) begin
            mode_r <= mda_mode_e'(bus.mode);
        end else begin
            mode_r <= mode_r;
        end
    end

    // Final output stage: colour mapping, blanking on sync loss, sync pass-through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_r       <= 1'b0;
            grn_r       <= 1'b0;
            blu_r       <= 1'b0;
            int_r       <= 1'b0;
            grn_int_r   <= 1'b0;
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            de_r        <= 1'b0;
            sync_lost_r <= 1'b0;
        end else begin
            red_r       <= pix_dly_s.video & rgb_s[2] & ~sync_lost_nxt_s;
            grn_r       <= pix_dly_s.video & rgb_s[1] & ~sync_lost_nxt_s;
            blu_r       <= pix_dly_s.video & rgb_s[0] & ~sync_lost_nxt_s;
            int_r       <= pix_dly_s.intensity & ~sync_lost_nxt_s;
            grn_int_r   <= pix_dly_s.intensity & rgb_s[1] & ~sync_lost_nxt_s;
            hs_r        <= pix_dly_s.hsync;
            vs_r        <= pix_dly_s.vsync;
            de_r        <= de_dly_s & ~sync_lost_nxt_s;
            sync_lost_r <= sync_lost_nxt_s;
        end
    end

    // Output clock divider: toggle every CLK_DIV/2 input cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            hclk_r    <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            hclk_r    <= ~hclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            hclk_r    <= hclk_r;
        end
    end

    assign bus.hdmi_red     = red_r;
    assign bus.hdmi_grn     = grn_r;
    assign bus.hdmi_blu     = blu_r;
    assign bus.hdmi_int     = int_r;
    assign bus.hdmi_grn_int = grn_int_r;
    assign bus.hdmi_hs      = hs_r;
    assign bus.hdmi_vs      = vs_r;
    assign bus.hdmi_de      = de_r;
    assign bus.hdmi_clk     = hclk_r;
    assign bus.sync_lost    = sync_lost_r;

endmodule

// File: tb/tb_mda_hdmi_pipe.sv
// Bench for mda_hdmi_pipe: two configurations driven by the same stimulus,
// checked every cycle against a history-based reference model, plus
// hand-computed pins on the key latencies, colour changes, divider and watchdog.
module tb_mda_hdmi_pipe;

`ifdef MDA_SYNC_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int N = 4096;
    localparam int B_RED = 9, B_GRN = 8, B_BLU = 7, B_INT = 6, B_GINT = 5;
    localparam int B_HS = 4, B_VS = 3, B_DE = 2, B_CLK = 1, B_SL = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       video = 1'b0, intensity = 1'b0, hsync = 1'b0, vsync = 1'b0, display_enable = 1'b0;
    logic [1:0] mode = 2'd0;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    logic       h_rst [N];
    logic       h_vid [N];
    logic       h_int [N];
    logic       h_hs  [N];
    logic       h_vs  [N];
    logic       h_de  [N];
    logic [1:0] h_mode [N];

    mda_hdmi_if if0();
    mda_hdmi_if if1();

    assign if0.video = video;          assign if1.video = video;
    assign if0.intensity = intensity;  assign if1.intensity = intensity;
    assign if0.hsync = hsync;          assign if1.hsync = hsync;
    assign if0.vsync = vsync;          assign if1.vsync = vsync;
    assign if0.display_enable = display_enable;
    assign if1.display_enable = display_enable;
    assign if0.mode = mode;            assign if1.mode = mode;

    mda_hdmi_pipe #(.DE_DELAY(2), .PIX_DELAY(0), .CLK_DIV(2), .SYNC_TIMEOUT(100)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    mda_hdmi_pipe #(.DE_DELAY(0), .PIX_DELAY(3), .CLK_DIV(6), .SYNC_TIMEOUT(100)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    logic [9:0] act0, act1;
    assign act0 = {if0.hdmi_red, if0.hdmi_grn, if0.hdmi_blu, if0.hdmi_int, if0.hdmi_grn_int,
                   if0.hdmi_hs, if0.hdmi_vs, if0.hdmi_de, if0.hdmi_clk, if0.sync_lost};
    assign act1 = {if1.hdmi_red, if1.hdmi_grn, if1.hdmi_blu, if1.hdmi_int, if1.hdmi_grn_int,
                   if1.hdmi_hs, if1.hdmi_vs, if1.hdmi_de, if1.hdmi_clk, if1.sync_lost};

    always #5 clk = ~clk;

    // Record what the design saw at each rising edge, indexed by edge number.
    always @(posedge clk) begin
        if (ecnt < N) begin
            h_rst[ecnt]  <= rst_n;
            h_vid[ecnt]  <= video;
            h_int[ecnt]  <= intensity;
            h_hs[ecnt]   <= hsync;
            h_vs[ecnt]   <= vsync;
            h_de[ecnt]   <= display_enable;
            h_mode[ecnt] <= mode;
        end
        ecnt <= ecnt + 1;
    end

    // ---------------- reference model (history based) ----------------
    // True when no reset was sampled on edges a..b.
    function automatic bit okwin(int a, int b);
        if (a < 0) return 1'b0;
        for (int i = a; i <= b; i++) begin
            if (!h_rst[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Value registered at edge e of an input delayed by d extra stages.
    function automatic logic pick(int e, int d, int sel);
        int a;
        a = e - d;
        if (!okwin(a, e)) return 1'b0;
        case (sel)
            0:       return h_vid[a];
            1:       return h_int[a];
            2:       return h_hs[a];
            3:       return h_vs[a];
            default: return h_de[a];
        endcase
    endfunction

    function automatic bit edge_at(int e, int p);
        logic prev;
        if (e < 0) return 1'b0;
        prev = (e >= 1) ? pick(e - 1, p, 3) : 1'b0;
        return h_rst[e] && pick(e, p, 3) && !prev;
    endfunction

    // Mode in force for the output produced at edge e.
    function automatic logic [1:0] mode_before(int e, int p);
        for (int k = e - 1; k >= 0; k--) begin
            if (!h_rst[k]) return 2'd0;
            if (edge_at(k, p)) return h_mode[k];
        end
        return 2'd0;
    endfunction

    // Lost when the last T edges before e saw neither reset nor vsync edge.
    function automatic bit lost_at(int e, int p, int t);
        int lo;
        if (!WD) return 1'b0;
        if (!h_rst[e] || edge_at(e, p)) return 1'b0;
        lo = (e - t < 0) ? 0 : e - t;
        for (int j = e - 1; j >= lo; j--) begin
            if (!h_rst[j] || edge_at(j, p)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [2:0] rgb_of(logic [1:0] m);
        case (m)
            2'd0:    return 3'b010;
            2'd1:    return 3'b110;
            2'd2:    return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [9:0] model_out(int e, int de_d, int p, int half, int t);
        logic lost, v, i, hs, vs, de, c;
        logic [2:0] rgb;
        int k;
        lost = lost_at(e, p, t);
        v  = pick(e, p, 0);
        i  = pick(e, p, 1);
        hs = pick(e, p, 2);
        vs = pick(e, p, 3);
        de = pick(e, de_d, 4);
        rgb = rgb_of(mode_before(e, p));
        k = e;
        while (k > 0 && h_rst[k]) k--;
        c = (((e - k) / half) % 2) == 1;
        return {v & rgb[2] & !lost, v & rgb[1] & !lost, v & rgb[0] & !lost,
                i & !lost, i & rgb[1] & !lost, hs, vs, de & !lost, c, lost};
    endfunction

    function automatic logic [9:0] exp_of(int d, int e);
        if (d == 0) return model_out(e, 2, 0, 1, 100);
        return model_out(e, 0, 3, 3, 100);
    endfunction

    function automatic string fname(int b);
        case (b)
            9: return "hdmi_red";   8: return "hdmi_grn";  7: return "hdmi_blu";
            6: return "hdmi_int";   5: return "hdmi_grn_int";
            4: return "hdmi_hs";    3: return "hdmi_vs";   2: return "hdmi_de";
            1: return "hdmi_clk";   default: return "sync_lost";
        endcase
    endfunction

    task automatic chk(string nm, logic act, logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b (edge %0d)", nm, act, want, ecnt - 1);
        end
    endtask

    task automatic cmp_vec(string pre, logic [9:0] a, logic [9:0] m);
        for (int b = 0; b < 10; b++) begin
            chk({pre, "_", fname(b)}, a[b], m[b]);
        end
    endtask

    // Literal pin: checks both the design and the model against a hand value.
    task automatic pin(string nm, int d, int b, logic want);
        logic [9:0] a, m;
        a = (d == 0) ? act0 : act1;
        m = exp_of(d, ecnt - 1);
        chk({nm, "_dut"}, a[b], want);
        chk({nm, "_model"}, m[b], want);
    endtask

    // Every-cycle comparison of both designs against the model.
    always @(negedge clk) begin
        if (ecnt > 0 && ecnt < N) begin
            cmp_vec("d0", act0, exp_of(0, ecnt - 1));
            cmp_vec("d1", act1, exp_of(1, ecnt - 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        gap = 0;

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // DE latency 3 / 1, video latency 1, hsync latency 4 on the deep pixel path.
        display_enable = 1'b1; video = 1'b1; hsync = 1'b1;
        tick();
        pin("grn_lat1", 0, B_GRN, 1'b1);
        pin("de_early", 0, B_DE, 1'b0);
        pin("de_lat1_d1", 1, B_DE, 1'b1);
        display_enable = 1'b0; video = 1'b0; hsync = 1'b0;
        tick();
        pin("de_mid", 0, B_DE, 1'b0);
        tick();
        pin("de_lat3", 0, B_DE, 1'b1);
        pin("hs_early_d1", 1, B_HS, 1'b0);
        tick();
        pin("hs_lat4_d1", 1, B_HS, 1'b1);
        pin("de_after", 0, B_DE, 1'b0);

        // Mode change mid-frame stays green until the vsync edge.
        mode = 2'd2; video = 1'b1;
        repeat (4) tick();
        pin("midframe_red", 0, B_RED, 1'b0);
        pin("midframe_grn", 0, B_GRN, 1'b1);
        vsync = 1'b1;
        tick();
        pin("edge_cycle_blu", 0, B_BLU, 1'b0);
        tick();
        pin("white_red", 0, B_RED, 1'b1);
        pin("white_grn", 0, B_GRN, 1'b1);
        pin("white_blu", 0, B_BLU, 1'b1);
        vsync = 1'b0;
        repeat (3) tick();
        mode = 2'd3; vsync = 1'b1; intensity = 1'b1;
        tick();
        pin("same_cycle_old", 0, B_BLU, 1'b1);
        vsync = 1'b0;
        tick();
        pin("red_gint", 0, B_GINT, 1'b0);
        pin("red_int", 0, B_INT, 1'b1);
        pin("red_red", 0, B_RED, 1'b1);
        pin("red_grn", 0, B_GRN, 1'b0);

        // Reset mid-period restarts the divider.
        rst_n = 1'b0;
        tick();
        pin("rst_clk_d1", 1, B_CLK, 1'b0);
        pin("rst_clk_d0", 0, B_CLK, 1'b0);
        pin("rst_red", 0, B_RED, 1'b0);
        rst_n = 1'b1;
        tick();
        pin("div1_d1", 1, B_CLK, 1'b0);
        pin("div1_d0", 0, B_CLK, 1'b1);
        tick();
        pin("div2_d1", 1, B_CLK, 1'b0);
        tick();
        pin("div3_d1", 1, B_CLK, 1'b1);
        repeat (3) tick();
        pin("div6_d1", 1, B_CLK, 1'b0);

        // Watchdog: no vsync for the timeout, then recovery on the next edge.
        mode = 2'd0; video = 1'b1; display_enable = 1'b1; intensity = 1'b1; vsync = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        pin("wd_before", 0, B_SL, 1'b0);
        pin("wd_de_before", 0, B_DE, 1'b1);
        tick();
        pin("wd_lost", 0, B_SL, WD);
        pin("wd_lost_d1", 1, B_SL, WD);
        pin("wd_blank_de", 0, B_DE, !WD);
        pin("wd_blank_grn", 0, B_GRN, !WD);
        repeat (10) tick();
        pin("wd_still", 0, B_SL, WD);
        vsync = 1'b1;
        tick();
        pin("wd_recover", 0, B_SL, 1'b0);
        pin("wd_recover_de", 0, B_DE, 1'b1);
        vsync = 1'b0;

        // Randomised frames with occasional long sync gaps and resets.
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            video = 1'($urandom);
            intensity = 1'($urandom);
            hsync = 1'($urandom);
            display_enable = 1'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if (gap == 0) gap = int'($urandom_range(20, 170));
            vsync = (gap <= 3);
            gap = gap - 1;
            tick();
        end
        rst_n = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mda_hdmi_pipe.md
MDA_HDMI_PIPE -- requirements
Module: mda_hdmi_pipe

Interface
REQ-001 SHALL have parameter DE_DELAY, default 2, meaning extra DE register stages (range 0..15).
REQ-002 SHALL have parameter PIX_DELAY, default 0, meaning extra stages on video/intensity/hsync/vsync (range 0..15).
REQ-003 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per hdmi_clk period (even, >=2).
REQ-004 SHALL have parameter SYNC_TIMEOUT, default 1048576, meaning clk cycles without a vsync rising edge before loss is declared.
REQ-005 SHALL have ports:
- clk  in  1  pixel clock; one clock only.
- rst_n  in  1  reset; synchronous, active-low.
- video, intensity, hsync, vsync, display_enable  in  1 each  MDA pixel/timing inputs.
- mode  in  2  colour select (switch pair).
- hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int  out  1 each  colour outputs.
- hdmi_hs, hdmi_vs, hdmi_de  out  1 each  timing outputs.
- hdmi_clk  out  1  divided pixel clock.
- sync_lost  out  1  watchdog flag.

Function
REQ-006 SHALL delay display_enable by exactly 1+DE_DELAY cycles to hdmi_de.
REQ-007 SHALL delay video, intensity, hsync and vsync by exactly 1+PIX_DELAY cycles, with colour mapping applied in the final stage.
REQ-008 SHALL map the active mode (r,g,b): 0 green (0,1,0), 1 yellow (1,1,0), 2 white (1,1,1), 3 red (1,0,0); each colour output = delayed video AND mode bit.
REQ-009 SHALL drive hdmi_int = delayed intensity and hdmi_grn_int = delayed intensity AND mode green bit.
REQ-010 SHALL hold the active mode in a register updated only on a vsync rising edge (delayed vsync 0->1 between consecutive cycles); no mid-frame colour change.
REQ-011 SHALL, when the mode input changes in the same cycle as the vsync rising edge, capture the value present in that cycle and apply it from the next output cycle.
REQ-012 SHALL generate hdmi_clk from a counter 0..CLK_DIV/2-1, toggling hdmi_clk and wrapping to 0 when the counter reaches CLK_DIV/2-1; CLK_DIV=2 toggles every cycle.
REQ-013 SHALL count cycles since the last vsync rising edge, saturating at SYNC_TIMEOUT, and clear the count to 0 on each rising edge.
REQ-014 SHALL assert sync_lost the cycle after the count reaches SYNC_TIMEOUT, and deassert it the cycle after the next vsync rising edge.
REQ-015 SHALL force hdmi_red/grn/blu/int/grn_int and hdmi_de to 0 while sync_lost=1; hdmi_hs, hdmi_vs and hdmi_clk are unaffected.

Reset
REQ-016 SHALL, on rst_n=0 at a clk edge, clear all delay stages, outputs, hdmi_clk, divider counter, watchdog counter and sync_lost to 0, and set the active mode to 0 (green).
REQ-017 SHALL apply reset mid-frame or mid-divide with no partial state retained; after release, outputs reflect inputs only after the full pipeline latency.

Configuration
REQ-018 SHALL, with MDA_SYNC_WATCHDOG_EN defined, implement REQ-013..015.
REQ-019 SHALL, without MDA_SYNC_WATCHDOG_EN, omit the watchdog counter, tie sync_lost to 0 and never force blanking; all other behaviour is identical.

Structure
REQ-020 SHALL place the mode enum (GREEN, YELLOW, WHITE, RED), the 4-entry RGB table and the default parameter constants in shared package mda_hdmi_pkg.
REQ-021 SHALL implement both delay paths with one parametrised sub-module, mda_delay_line (WIDTH, DEPTH; DEPTH=0 is a wire), using the same synchronous reset.

Verification
REQ-022 Defaults; display_enable pulse at cycle 10 -> hdmi_de high at cycle 13; video high at cycle 10 -> hdmi_grn high at cycle 11.
REQ-023 mode 0->2 mid-frame -> colours stay green until the vsync rising edge, then video=1 gives (1,1,1); mode=3 gives hdmi_grn_int=0 with intensity=1.
REQ-024 CLK_DIV=6 -> hdmi_clk toggles every 3 cycles; rst_n low mid-period -> hdmi_clk=0 and count restarts.
REQ-025 With MDA_SYNC_WATCHDOG_EN and SYNC_TIMEOUT=100, no vsync for 100 cycles -> sync_lost=1, colours and de forced 0; next vsync edge -> sync_lost=0 one cycle later.
REQ-026 DE_DELAY=0, PIX_DELAY=3 -> hdmi_de latency 1 and hdmi_hs latency 4; macro undefined -> sync_lost stays 0 under the REQ-025 stimulus.
